// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared types and constants for the data memory controller
package data_memory_pkg;

   typedef enum logic [1:0] {INIT, IDLE, WAIT} state_e;

   localparam int PRELOAD_LEN = 4;
   localparam int WAIT_CNT_W  = 4;

   // Element [0] is written first.
   localparam logic [PRELOAD_LEN-1:0][7:0] PRELOAD_TBL = {8'd9, 8'd150, 8'd7, 8'd150};

endpackage

// File: rtl/data_memory_ctrl_mem_array.sv
// rtl/data_memory_ctrl_mem_array.sv - single-port storage, sync write, registered read
module mem_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Same-address collision returns the data being written.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - handshaked data memory with wait states and reset-time preload
module data_memory_ctrl
   import data_memory_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 8,
   parameter int WAIT_STATES  = 0,
   parameter int PRELOAD_EN   = 1,
   parameter int PRELOAD_BASE = 100
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              memWrite,
   input  logic              memRead,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] out,
   output logic              ready,
   output logic              done
);

   localparam bit                    ZERO_WAIT   = (WAIT_STATES == 0);
   localparam logic [WAIT_CNT_W-1:0] WAIT_INIT   = WAIT_CNT_W'(WAIT_STATES);
   localparam logic [ADDR_W-1:0]     BASE        = ADDR_W'(PRELOAD_BASE);
   localparam state_e                RESET_STATE = (PRELOAD_EN != 0) ? INIT : IDLE;

   state_e                  state_q, state_d;
   logic [1:0]              idx_q, idx_d;
   logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic                    done_q;
   logic                    rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic                    accept, complete;
   logic                    op_rd, op_wr;
   logic [ADDR_W-1:0]       op_addr;
   logic [DATA_W-1:0]       op_data;
   logic                    preloading;
   logic                    mem_we, mem_re;
   logic [ADDR_W-1:0]       mem_waddr;
   logic [DATA_W-1:0]       mem_wdata;

   assign accept = ready_q & (memRead | memWrite);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      complete = 1'b0;
      if (accept) begin
         rd_d   = memRead;
         wr_d   = memWrite;
         addr_d = address;
         data_d = data;
      end
      unique case (state_q)
         INIT: begin
            idx_d   = idx_q + 2'd1;
            ready_d = 1'b0;
            if (idx_q == 2'(PRELOAD_LEN - 1)) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
         end
         IDLE: begin
            ready_d = 1'b1;
            if (accept) begin
               if (ZERO_WAIT) begin
                  complete = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
                  ready_d = 1'b0;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
            if (cnt_q == WAIT_CNT_W'(1)) begin
               complete = 1'b1;
               state_d  = IDLE;
               ready_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b0;
         end
      endcase
   end

   // Zero-wait accesses complete on the accept edge, so they use the live request.
   assign op_rd   = ZERO_WAIT ? memRead  : rd_q;
   assign op_wr   = ZERO_WAIT ? memWrite : wr_q;
   assign op_addr = ZERO_WAIT ? address  : addr_q;
   assign op_data = ZERO_WAIT ? data     : data_q;

   assign preloading = (state_q == INIT);
   assign mem_we     = ~reset & (preloading | (complete & op_wr));
   assign mem_re     = complete & op_rd;
   assign mem_waddr  = preloading ? (BASE + ADDR_W'(idx_q)) : op_addr;
   assign mem_wdata  = preloading ? DATA_W'(PRELOAD_TBL[idx_q]) : op_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RESET_STATE;
         idx_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         done_q  <= complete;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem_array (
      .clk_i   (clock),
      .rst_i   (reset),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wdata_i (mem_wdata),
      .re_i    (mem_re),
      .raddr_i (op_addr),
      .rdata_o (out)
   );

   assign ready = ready_q;
   assign done  = done_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - randomized bench for data_memory_ctrl against an array model
module tb_data_memory_ctrl;

   localparam int N = 3;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_s  [N];
   logic       rd_s   [N];
   logic       wr_s   [N];
   logic       rdy_s  [N];
   logic       done_s [N];
   logic [7:0] addr_s [N];
   logic [7:0] data_s [N];
   logic [7:0] out_s  [N];

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] ref_mem [N][256];
   logic [7:0] ref_out [N];

   // Instance 0: zero wait; instance 1: three wait states; instance 2: one wait, no preload.
   data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(0), .PRELOAD_EN(1), .PRELOAD_BASE(100)) u_dut0 (
      .clock(clk), .reset(rst_s[0]), .memWrite(wr_s[0]), .memRead(rd_s[0]), .address(addr_s[0]),
      .data(data_s[0]), .out(out_s[0]), .ready(rdy_s[0]), .done(done_s[0]));
   data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(3), .PRELOAD_EN(1), .PRELOAD_BASE(100)) u_dut1 (
      .clock(clk), .reset(rst_s[1]), .memWrite(wr_s[1]), .memRead(rd_s[1]), .address(addr_s[1]),
      .data(data_s[1]), .out(out_s[1]), .ready(rdy_s[1]), .done(done_s[1]));
   data_memory_ctrl #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(1), .PRELOAD_EN(0), .PRELOAD_BASE(100)) u_dut2 (
      .clock(clk), .reset(rst_s[2]), .memWrite(wr_s[2]), .memRead(rd_s[2]), .address(addr_s[2]),
      .data(data_s[2]), .out(out_s[2]), .ready(rdy_s[2]), .done(done_s[2]));

   function automatic int ws(int k);
      return (k == 0) ? 0 : (k == 1) ? 3 : 1;
   endfunction

   function automatic bit pe(int k);
      return k != 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int k);
      int cnt;
      int dcnt;
      @(negedge clk);
      rst_s[k] = 1'b1;
      rd_s[k]  = 1'b0;
      wr_s[k]  = 1'b0;
      @(negedge clk);
      check($sformatf("rst_ready%0d", k), rdy_s[k], 0);
      check($sformatf("rst_done%0d", k), done_s[k], 0);
      check($sformatf("rst_out%0d", k), out_s[k], 0);
      if (pe(k)) begin
         ref_mem[k][100] = 8'd150;
         ref_mem[k][101] = 8'd7;
         ref_mem[k][102] = 8'd150;
         ref_mem[k][103] = 8'd9;
      end
      ref_out[k] = 8'd0;
      rst_s[k] = 1'b0;
      cnt  = 0;
      dcnt = 0;
      while (!rdy_s[k] && cnt < 20) begin
         cnt++;
         @(negedge clk);
         if (done_s[k]) dcnt++;
      end
      check($sformatf("ready_low_after_reset%0d", k), cnt, pe(k) ? 4 : 1);
      check($sformatf("no_done_in_init%0d", k), dcnt, 0);
   endtask

   task automatic access(input int k, input bit rd, input bit wr, input int a,
                         input logic [7:0] d, input bit junk);
      int to;
      int lat;
      int low;
      to = 0;
      while (!rdy_s[k] && to < 50) begin
         @(negedge clk);
         to++;
      end
      check($sformatf("ready_timeout%0d", k), (to < 50), 1);
      rd_s[k]   = rd;
      wr_s[k]   = wr;
      addr_s[k] = 8'(a);
      data_s[k] = d;
      if (wr) ref_mem[k][a & 255] = d;
      if (rd) ref_out[k] = ref_mem[k][a & 255];
      @(negedge clk);
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
      if (junk) begin
         rd_s[k]   = 1'b1;
         wr_s[k]   = 1'b1;
         addr_s[k] = 8'($urandom_range(0, 31));
         data_s[k] = 8'($urandom);
      end
      lat = 1;
      low = 0;
      while (!done_s[k] && lat < 50) begin
         if (!rdy_s[k]) low++;
         @(negedge clk);
         lat++;
      end
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
      check($sformatf("latency%0d@%0h", k, a), lat, ws(k) + 1);
      check($sformatf("ready_low%0d@%0h", k, a), low, ws(k));
      check($sformatf("out%0d@%0h", k, a), out_s[k], ref_out[k]);
   endtask

   task automatic abort_write(input int k);
      int to;
      to = 0;
      while (!rdy_s[k] && to < 50) begin
         @(negedge clk);
         to++;
      end
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b1;
      addr_s[k] = 8'd102;
      data_s[k] = 8'hAA;
      @(negedge clk);
      wr_s[k] = 1'b0;
      @(negedge clk);
      check($sformatf("abort_no_done_yet%0d", k), done_s[k], 0);
      rst_s[k] = 1'b1;
      do_reset(k);
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         rst_s[k] = 1'b0;
         rd_s[k] = 1'b0;
         wr_s[k] = 1'b0;
         addr_s[k] = '0;
         data_s[k] = '0;
         ref_out[k] = '0;
         for (int i = 0; i < 256; i++) ref_mem[k][i] = '0;
      end

      for (int k = 0; k < N; k++) do_reset(k);

      // Preload contents.
      for (int a = 100; a < 104; a++) access(0, 1'b1, 1'b0, a, 8'h00, 1'b0);
      access(1, 1'b1, 1'b0, 101, 8'h00, 1'b1);

      // Back-to-back write then read at zero wait.
      access(0, 1'b0, 1'b1, 'h10, 8'h5A, 1'b0);
      access(0, 1'b1, 1'b0, 'h10, 8'h00, 1'b0);

      // Read and write together: write-first.
      for (int k = 0; k < N; k++) begin
         access(k, 1'b1, 1'b1, 'h20, 8'h33, 1'b0);
         access(k, 1'b0, 1'b0 | 1'b1, 'h21, 8'h44, 1'b0);
         access(k, 1'b1, 1'b0, 'h20, 8'h00, 1'b0);
      end

      // Reset in the middle of a waited write discards it.
      abort_write(1);
      access(1, 1'b1, 1'b0, 102, 8'h00, 1'b0);

      // No preload; top address and wrap.
      access(2, 1'b0, 1'b1, 'hFF, 8'hC3, 1'b0);
      access(2, 1'b1, 1'b0, 'hFF, 8'h00, 1'b0);
      access(2, 1'b0, 1'b1, 'h100, 8'h6E, 1'b0);
      access(2, 1'b1, 1'b0, 'h00, 8'h00, 1'b0);

      // Randomized traffic over a known-initialised address window.
      for (int k = 0; k < N; k++) begin
         for (int a = 0; a < 32; a++) access(k, 1'b0, 1'b1, a, 8'($urandom), 1'b0);
         for (int t = 0; t < 40; t++) begin
            int a;
            int op;
            int gap;
            a   = ($urandom_range(0, 4) == 0) ? 100 + $urandom_range(0, 3) : $urandom_range(0, 31);
            if (!pe(k) && a >= 100) a = a - 100;
            op  = $urandom_range(1, 3);
            gap = $urandom_range(0, 2);
            access(k, op[0], op[1], a, 8'($urandom), (ws(k) > 0) && ($urandom_range(0, 1) == 1));
            for (int g = 0; g < gap; g++) @(negedge clk);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
